// File: rtl/neurospider_host_sequencer.sv
// Host-port bus initiator for NeuroSpider: turns cache-load words and job descriptors
// into register/cache bus cycles, runs the job and returns the result word.
module neurospider_host_sequencer #(
    parameter logic [15:0] OFFSET_REG    = 16'h8000,
    parameter logic [15:0] DEST_REG      = 16'h8001,
    parameter logic [15:0] NUMOPS_REG    = 16'h8002,
    parameter logic [15:0] ROUTER_REG    = 16'h8003,
    parameter logic [15:0] CTRL_REG      = 16'h8004,
    parameter logic [15:0] RESULT_ROUTER = 16'h0004,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_router,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_err,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [15:0] job_offset,
    input  logic [15:0] job_dest,
    input  logic [15:0] job_numops,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic        WE,
    output logic [15:0] Address,
    output logic [15:0] DataWrite,
    output logic        StartOperation,
    input  logic        ReadyNextOperation,
    input  logic [15:0] DataRead
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + READ_LATENCY + 1);

    typedef enum logic [3:0] {
        IDLE, LD_ROUTER, LD_DATA, CFG_OFF, CFG_DEST, CFG_NOPS, CFG_CTRL,
        START, WAIT_READY, RD_ROUTER, RD_ADDR, RESP
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [15:0]        shadow, shadow_d;
    logic               shadow_valid, shadow_valid_d;
    logic [15:0]        ld_router_q, ld_router_d, ld_addr_q, ld_addr_d, ld_data_q, ld_data_d;
    logic [15:0]        job_offset_q, job_offset_d, job_dest_q, job_dest_d;
    logic [15:0]        job_numops_q, job_numops_d;
    logic [15:0]        res_data_d;
    logic               res_err_d, ld_ready_d, ld_err_d, job_ready_d;
    logic               we_d, start_d;
    logic [15:0]        address_d, data_write_d;

    // Next state, captured fields, then bus outputs decoded from the state being entered
    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        shadow_d       = shadow;
        shadow_valid_d = shadow_valid;
        ld_router_d    = ld_router_q;
        ld_addr_d      = ld_addr_q;
        ld_data_d      = ld_data_q;
        job_offset_d   = job_offset_q;
        job_dest_d     = job_dest_q;
        job_numops_d   = job_numops_q;
        res_data_d     = res_data;
        res_err_d      = res_err;
        ld_ready_d     = 1'b0;
        ld_err_d       = 1'b0;
        job_ready_d    = 1'b0;
        we_d           = 1'b0;
        start_d        = 1'b0;
        address_d      = '0;
        data_write_d   = '0;

        case (state)
            // ready is registered, so skip the cycle in which the previous handshake completes
            IDLE: if (!ld_ready && !job_ready) begin
                if (ld_valid) begin
                    ld_ready_d = 1'b1;
                    if (ld_addr[15]) begin
                        ld_err_d = 1'b1;
                    end else begin
                        ld_router_d = ld_router;
                        ld_addr_d   = ld_addr;
                        ld_data_d   = ld_data;
                        if (!shadow_valid || shadow != ld_router) begin
                            shadow_d       = ld_router;
                            shadow_valid_d = 1'b1;
                            state_d        = LD_ROUTER;
                        end else begin
                            state_d = LD_DATA;
                        end
                    end
                end else if (job_valid) begin
                    job_ready_d  = 1'b1;
                    job_offset_d = job_offset;
                    job_dest_d   = job_dest;
                    job_numops_d = job_numops;
                    state_d      = CFG_OFF;
                end
            end
            LD_ROUTER: state_d = LD_DATA;
            LD_DATA:   state_d = IDLE;
            CFG_OFF:   state_d = CFG_DEST;
            CFG_DEST:  state_d = CFG_NOPS;
            CFG_NOPS:  state_d = CFG_CTRL;
            CFG_CTRL:  state_d = START;
            START: begin
                cnt_d   = '0;
                state_d = WAIT_READY;
            end
            // cnt==0 is the cycle where Ready may still reflect the previous operation
            WAIT_READY: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt != '0 && ReadyNextOperation) begin
                    shadow_d       = RESULT_ROUTER;
                    shadow_valid_d = 1'b1;
                    state_d        = RD_ROUTER;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RD_ROUTER: begin
                cnt_d   = '0;
                state_d = RD_ADDR;
            end
            RD_ADDR: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(READ_LATENCY - 1)) begin
                    res_data_d = DataRead;
                    res_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            LD_ROUTER: begin we_d = 1'b1; address_d = ROUTER_REG; data_write_d = ld_router_d;   end
            LD_DATA:   begin we_d = 1'b1; address_d = ld_addr_d;  data_write_d = ld_data_d;     end
            CFG_OFF:   begin we_d = 1'b1; address_d = OFFSET_REG; data_write_d = job_offset_d;  end
            CFG_DEST:  begin we_d = 1'b1; address_d = DEST_REG;   data_write_d = job_dest_d;    end
            CFG_NOPS:  begin we_d = 1'b1; address_d = NUMOPS_REG; data_write_d = job_numops_d;  end
            CFG_CTRL:  begin we_d = 1'b1; address_d = CTRL_REG;   data_write_d = '0;            end
            START:     start_d = 1'b1;
            RD_ROUTER: begin we_d = 1'b1; address_d = ROUTER_REG; data_write_d = RESULT_ROUTER; end
            RD_ADDR:   address_d = job_dest_d;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            shadow         <= '0;
            shadow_valid   <= 1'b0;
            ld_router_q    <= '0;
            ld_addr_q      <= '0;
            ld_data_q      <= '0;
            job_offset_q   <= '0;
            job_dest_q     <= '0;
            job_numops_q   <= '0;
            res_data       <= '0;
            res_err        <= 1'b0;
            res_valid      <= 1'b0;
            ld_ready       <= 1'b0;
            ld_err         <= 1'b0;
            job_ready      <= 1'b0;
            busy           <= 1'b0;
            WE             <= 1'b0;
            Address        <= '0;
            DataWrite      <= '0;
            StartOperation <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            shadow         <= shadow_d;
            shadow_valid   <= shadow_valid_d;
            ld_router_q    <= ld_router_d;
            ld_addr_q      <= ld_addr_d;
            ld_data_q      <= ld_data_d;
            job_offset_q   <= job_offset_d;
            job_dest_q     <= job_dest_d;
            job_numops_q   <= job_numops_d;
            res_data       <= res_data_d;
            res_err        <= res_err_d;
            res_valid      <= (state_d == RESP);
            ld_ready       <= ld_ready_d;
            ld_err         <= ld_err_d;
            job_ready      <= job_ready_d;
            busy           <= (state_d != IDLE);
            WE             <= we_d;
            Address        <= address_d;
            DataWrite      <= data_write_d;
            StartOperation <= start_d;
        end
    end
endmodule

// File: tb/tb_neurospider_host_sequencer.sv
// Directed bench for neurospider_host_sequencer: load table, job/readback, timeout,
// priority, shadow-hit and mid-operation reset sequences.
module tb_neurospider_host_sequencer;
    localparam int unsigned TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready, ld_err;
    logic [15:0] ld_router, ld_addr, ld_data;
    logic        job_valid, job_ready;
    logic [15:0] job_offset, job_dest, job_numops;
    logic        res_valid, res_ready, res_err, busy;
    logic [15:0] res_data;
    logic        WE, StartOperation, ReadyNextOperation;
    logic [15:0] Address, DataWrite, DataRead;

    neurospider_host_sequencer dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_router(ld_router),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err),
        .job_valid(job_valid), .job_ready(job_ready), .job_offset(job_offset),
        .job_dest(job_dest), .job_numops(job_numops),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy),
        .WE(WE), .Address(Address), .DataWrite(DataWrite),
        .StartOperation(StartOperation), .ReadyNextOperation(ReadyNextOperation),
        .DataRead(DataRead)
    );

    always #5 clk = ~clk;

    // Result cache contents seen by the readback
    always_comb begin
        case (Address)
            16'h0000: DataRead = 16'h4500;
            16'h0005: DataRead = 16'h1234;
            default:  DataRead = 16'hdead;
        endcase
    end

    logic [31:0] bus_log[$];
    int          n_start = 0;
    int          n_lderr = 0;

    always @(negedge clk) begin
        if (WE) bus_log.push_back({Address, DataWrite});
        if (StartOperation) n_start++;
        if (ld_err) n_lderr++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ent(input int i);
        if (i < bus_log.size()) return bus_log[i];
        return 32'hffff_ffff;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!StartOperation && n < 100) begin tick(); n++; end
        chk("start_seen", 32'(StartOperation), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] r, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        ld_router = r; ld_addr = a; ld_data = d; ld_valid = 1'b1;
        while (!ld_ready && n < 50) begin tick(); n++; end
        chk("ld_ready_seen", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic do_job(input logic [15:0] o, input logic [15:0] d, input logic [15:0] nops);
        int n = 0;
        job_offset = o; job_dest = d; job_numops = nops; job_valid = 1'b1;
        while (!job_ready && n < 50) begin tick(); n++; end
        chk("job_ready_seen", 32'(job_ready), 32'd1);
        chk("job_first_write", {15'd0, WE, Address}, {15'd0, 1'b1, 16'h8000});
        tick();
        job_valid = 1'b0;
    endtask

    task automatic consume_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
    endtask

    typedef struct {
        logic [15:0] router;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_rtr;
        logic        exp_err;
    } ld_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        ld_vec_t vecs[7];
        int      rtr_total;
        int      e0, s0, n, exp_n;

        vecs[0] = '{16'h0000, 16'h0000, 16'h3c00, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'h4000, 1'b0, 1'b0};
        vecs[2] = '{16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'h0003, 16'h0000, 16'h3c00, 1'b1, 1'b0};
        vecs[5] = '{16'h0003, 16'h0001, 16'h4000, 1'b0, 1'b0};
        vecs[6] = '{16'h0003, 16'h8001, 16'h1234, 1'b0, 1'b1};

        rst = 1'b1;
        ld_valid = 1'b0; ld_router = '0; ld_addr = '0; ld_data = '0;
        job_valid = 1'b0; job_offset = '0; job_dest = '0; job_numops = '0;
        res_ready = 1'b0; ReadyNextOperation = 1'b0;
        repeat (3) tick();
        chk("rst_flags", {24'd0, WE, StartOperation, res_valid, res_err, ld_ready, job_ready, ld_err, busy}, 32'd0);
        chk("rst_bus", {Address, DataWrite}, 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_flags", {24'd0, WE, StartOperation, res_valid, res_err, ld_ready, job_ready, ld_err, busy}, 32'd0);

        // Load table
        rtr_total = 0;
        for (int i = 0; i < 7; i++) begin
            bus_log.delete();
            e0 = n_lderr;
            do_load(vecs[i].router, vecs[i].addr, vecs[i].data);
            wait_idle();
            exp_n = vecs[i].exp_err ? 0 : (vecs[i].exp_rtr ? 2 : 1);
            chk($sformatf("ld%0d_nwrites", i), 32'(bus_log.size()), 32'(exp_n));
            chk($sformatf("ld%0d_err", i), 32'(n_lderr - e0), 32'(vecs[i].exp_err));
            if (vecs[i].exp_rtr)
                chk($sformatf("ld%0d_router_wr", i), ent(0), {16'h8003, vecs[i].router});
            if (!vecs[i].exp_err)
                chk($sformatf("ld%0d_data_wr", i), ent(exp_n - 1), {vecs[i].addr, vecs[i].data});
            foreach (bus_log[k]) if (bus_log[k][31:16] == 16'h8003) rtr_total++;
        end
        chk("router_writes_total", 32'(rtr_total), 32'd3);

        // Simultaneous load and job: load first, job at next IDLE, instant Ready
        bus_log.delete();
        ReadyNextOperation = 1'b1;
        ld_router = 16'h0003; ld_addr = 16'h0002; ld_data = 16'h00aa; ld_valid = 1'b1;
        job_offset = 16'h0001; job_dest = 16'h0005; job_numops = 16'h0003; job_valid = 1'b1;
        tick();
        chk("prio_ld_ready", 32'(ld_ready), 32'd1);
        chk("prio_job_wait", 32'(job_ready), 32'd0);
        tick();
        ld_valid = 1'b0;
        n = 0;
        while (!job_ready && n < 20) begin tick(); n++; end
        chk("prio_job_ready", 32'(job_ready), 32'd1);
        chk("prio_job_first_wr", {15'd0, WE, Address}, {15'd0, 1'b1, 16'h8000});
        tick();
        job_valid = 1'b0;
        wait_start();
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        chk("fast_start_to_res", 32'(n), 32'd5);
        chk("fast_res_data", 32'(res_data), 32'h1234);
        chk("fast_res_err", 32'(res_err), 32'd0);
        chk("fast_nwrites", 32'(bus_log.size()), 32'd6);
        chk("fast_wr0", ent(0), 32'h0002_00aa);
        chk("fast_wr1", ent(1), 32'h8000_0001);
        chk("fast_wr5", ent(5), 32'h8003_0004);
        consume_result();

        // Main job: Ready low 20 cycles after start
        bus_log.delete();
        ReadyNextOperation = 1'b0;
        s0 = n_start;
        do_job(16'h0000, 16'h0000, 16'h0002);
        wait_start();
        tick();
        chk("start_one_cycle", 32'(StartOperation), 32'd0);
        repeat (19) tick();
        ReadyNextOperation = 1'b1;
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        chk("job_res_valid", 32'(res_valid), 32'd1);
        chk("job_res_data", 32'(res_data), 32'h4500);
        chk("job_res_err", 32'(res_err), 32'd0);
        chk("job_nstart", 32'(n_start - s0), 32'd1);
        chk("job_nwrites", 32'(bus_log.size()), 32'd5);
        chk("job_wr0", ent(0), 32'h8000_0000);
        chk("job_wr1", ent(1), 32'h8001_0000);
        chk("job_wr2", ent(2), 32'h8002_0002);
        chk("job_wr3", ent(3), 32'h8004_0000);
        chk("job_wr4", ent(4), 32'h8003_0004);
        consume_result();

        // Shadow holds the result router after readback
        bus_log.delete();
        do_load(16'h0004, 16'h0002, 16'h0007);
        wait_idle();
        chk("shadow_hit_nwr", 32'(bus_log.size()), 32'd1);
        chk("shadow_hit_wr", ent(0), 32'h0002_0007);
        bus_log.delete();
        do_load(16'h0000, 16'h0003, 16'h0008);
        wait_idle();
        chk("shadow_miss_nwr", 32'(bus_log.size()), 32'd2);
        chk("shadow_miss_rtr", ent(0), 32'h8003_0000);
        chk("shadow_miss_wr", ent(1), 32'h0003_0008);

        // Timeout with result held back for 5 cycles
        ReadyNextOperation = 1'b0;
        do_job(16'h0007, 16'h0009, 16'h0001);
        wait_start();
        n = 0;
        while (!res_valid && n < int'(TIMEOUT) + 50) begin tick(); n++; end
        chk("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("timeout_hold%0d", c), {15'd0, res_valid, res_err, res_data}, {15'd0, 1'b1, 1'b1, 16'h0000});
            tick();
        end
        consume_result();
        chk("timeout_idle", 32'(busy), 32'd0);

        // Reset during WAIT_READY
        do_job(16'h0001, 16'h0002, 16'h0003);
        wait_start();
        repeat (3) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_flags", {28'd0, StartOperation, res_valid, busy, WE}, 32'd0);
        chk("mid_rst_addr", 32'(Address), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", {30'd0, busy, res_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neurospider_host_sequencer.md
Name: neurospider_host_sequencer

Overview:
- Bus initiator for the NeuroSpider host port: drives WE/Address/DataWrite/StartOperation and consumes ReadyNextOperation/DataRead.
- Turns two upstream valid/ready streams into NeuroSpider bus cycles: cache-load words and job descriptors (offset, dest, num_ops).
- For each job: programs the config registers, pulses StartOperation, waits for completion, reads the result word back from the result cache, and returns it on a result handshake.
- Sits between the system controller/DMA and the NeuroSpider core.

Parameters:
- OFFSET_REG, 16'h8000, offset register address
- DEST_REG, 16'h8001, destination register address
- NUMOPS_REG, 16'h8002, op-count register address
- ROUTER_REG, 16'h8003, cache router select register address
- CTRL_REG, 16'h8004, control register; written 16'h0000 before each start
- RESULT_ROUTER, 16'h0004, router value selecting the result cache for readback
- READ_LATENCY, 1, cycles from Address stable to DataRead valid (>=1)
- TIMEOUT, 1024, max cycles waiting for ReadyNextOperation

Ports:
- clk in 1 system clock
- rst in 1 synchronous active-high reset
- ld_valid in 1 load word valid
- ld_ready out 1 load word accepted
- ld_router in 16 cache router value (0=L1, 1=I0, 3=W0, ...)
- ld_addr in 16 cache location; bit 15 must be 0
- ld_data in 16 cache data
- ld_err out 1 one-cycle pulse: load word dropped (ld_addr[15]=1)
- job_valid in 1 job descriptor valid
- job_ready out 1 job accepted
- job_offset in 16 value for OFFSET_REG
- job_dest in 16 value for DEST_REG; also the readback location
- job_numops in 16 value for NUMOPS_REG
- res_valid out 1 result valid
- res_ready in 1 result consumed
- res_data out 16 result word (0 on error)
- res_err out 1 result is a timeout
- busy out 1 state != IDLE
- WE out 1 NeuroSpider write enable
- Address out 16 NeuroSpider address
- DataWrite out 16 NeuroSpider write data
- StartOperation out 1 NeuroSpider start strobe
- ReadyNextOperation in 1 NeuroSpider idle/done
- DataRead in 16 NeuroSpider read data

Behaviour:
- Reset: state IDLE; WE=0, StartOperation=0, Address=0, DataWrite=0, res_valid=0, res_err=0, res_data=0, ld_ready=0, job_ready=0, ld_err=0, busy=0; router shadow invalid. A reset asserted mid-operation aborts immediately and drives the same values the following cycle; there is no bus cleanup.
- All bus outputs are registered. Each bus write occupies exactly one cycle with WE=1. WE=0 in every non-write state.
- IDLE: if ld_valid, accept the load (ld_ready=1 for one cycle, capture fields). Otherwise, if job_valid, accept the job. Load has priority on simultaneous valid. At most one acceptance per cycle.
- Load path:
  - If ld_addr[15]=1: drop the word, pulse ld_err, return to IDLE.
  - Else if the shadow is invalid or differs from ld_router: LD_ROUTER writes ROUTER_REG=ld_router and updates the shadow.
  - Then LD_DATA writes ld_addr=ld_data, then IDLE.
  - Back-to-back loads with the same router issue one write each.
- Job path: CFG_OFF, CFG_DEST, CFG_NOPS, CFG_CTRL (writes 0), then START: WE=0, StartOperation=1 for exactly one cycle.
- WAIT_READY:
  - ReadyNextOperation is ignored on the first cycle after START.
  - Once it samples 1: go to RD_ROUTER.
  - Counter reaches TIMEOUT first: res_err=1, res_data=0, go to RESP.
  - Counter resets on each job.
- Readback:
  - RD_ROUTER writes ROUTER_REG=RESULT_ROUTER; shadow updated.
  - RD_ADDR: WE=0, Address=job_dest, held for READ_LATENCY cycles.
  - DataRead is captured into res_data on the last of those cycles; res_err=0.
- RESP: res_valid=1, with res_data/res_err stable, until res_ready is sampled 1; then IDLE. No new load or job is accepted while a result is pending.
- Widths: all data pass through unmodified; no arithmetic beyond the counters.
- Latency, job accept to first config write: 1 cycle. Job with instant Ready: res_valid asserts 7+READ_LATENCY cycles after accept (CFG×4, START, 1 ignored cycle, Ready sample, RD_ROUTER, RD_ADDR×READ_LATENCY, then RESP).

Test Plan:
- Reset then idle -> all outputs 0, busy=0. Assert rst during WAIT_READY -> next cycle IDLE, StartOperation=0, res_valid=0.
- Loads (0,0,3c00), (0,1,4000), (1,0,0000), (1,1,0001), (3,0,3c00), (3,1,4000) -> bus sequence:
  - 8003←0, 0000←3c00, 0001←4000
  - 8003←1, 0000←0000, 0001←0001
  - 8003←3, 0000←3c00, 0001←4000
  - exactly 3 router writes in total.
- Job (offset 0, dest 0, numops 2), Ready low 20 cycles then high, DataRead=4500 at addr 0 -> bus sequence:
  - 8000←0, 8001←0, 8002←2, 8004←0
  - one-cycle StartOperation
  - 8003←0004, read addr 0
  - result: res_valid with res_data=4500, res_err=0.
- Ready held low -> res_err=1, res_data=0 exactly TIMEOUT cycles after the ignored cycle; the bench holds res_ready=0 for 5 cycles, and the result must stay stable throughout.
- ld_valid and job_valid asserted together -> load accepted first, job accepted on the next IDLE. Load with ld_addr=8001 -> ld_err pulse, no bus write.
- Load with router 4 after a job readback -> no ROUTER_REG write (shadow hit). Load with router 0 afterwards -> 8003←0 written.
